// File: rtl/rx_module_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, frame width and
// derivation of the bit-period divider from clock and baud rate.
package rx_module_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  function automatic int calc_bps_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_bps_half(input int clk_freq, input int baud);
    return calc_bps_div(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/rx_bps_module.sv
// Bit-period counter for the receiver: runs while Count_Sig is high and
// raises BPS_CLK for one cycle in the middle of each bit period.
module rx_bps_module
  import rx_module_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Count_Sig,
  output logic BPS_CLK
);

  localparam int BPS_DIV  = calc_bps_div(CLK_FREQ, BAUD);
  localparam int BPS_HALF = calc_bps_half(CLK_FREQ, BAUD);
  localparam int CNT_W    = (BPS_DIV > 2) ? $clog2(BPS_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BPS_HALF - 1);

  logic [CNT_W-1:0] r_cnt;

  // Counter is held at zero whenever the receiver is idle, so every frame
  // starts its timing from the detected falling edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (!Count_Sig) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign BPS_CLK = Count_Sig & (r_cnt == CNT_MID);

endmodule

// File: rtl/rx_module.sv
// 8N1 UART receiver: input synchronizer, start/data/stop FSM, and a held
// output byte with valid/acknowledge handshake and error pulses.
module rx_module
  import rx_module_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 RX_Pin_In,
  input  logic                 en_RX,
  input  logic                 RX_Ack,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Done_Sig,
  output logic                 RX_Valid,
  output logic                 Frame_Err,
  output logic                 Overrun_Err,
  output logic                 BPS_CLK
);

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync_d;
  rx_state_e            r_state;
  rx_state_e            w_next_state;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_done;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_fall;
  logic w_count_sig;
  logic w_bps_clk;
  logic w_bit_clr;
  logic w_shift_en;
  logic w_good_frame;
  logic w_frame_err;

  // Two-flop synchronizer plus one delay stage for edge detection; idle-high reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= RX_Pin_In;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_fall      = r_sync_d & ~r_sync2;
  assign w_count_sig = (r_state != ST_IDLE);

  rx_bps_module #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_bps (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Count_Sig (w_count_sig),
    .BPS_CLK   (w_bps_clk)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-cycle strobes; a disabled receiver drops back to idle
  // without reporting anything about the partial frame.
  always_comb begin
    w_next_state = r_state;
    w_bit_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_good_frame = 1'b0;
    w_frame_err  = 1'b0;
    if (!en_RX) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            w_next_state = ST_START;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_START: begin
          if (w_bps_clk) begin
            w_bit_clr    = 1'b1;
            w_next_state = r_sync2 ? ST_IDLE : ST_DATA;
          end else begin
            w_next_state = ST_START;
          end
        end
        ST_DATA: begin
          if (w_bps_clk) begin
            w_shift_en   = 1'b1;
            w_next_state = (r_bit_idx == LAST_IDX) ? ST_STOP : ST_DATA;
          end else begin
            w_next_state = ST_DATA;
          end
        end
        ST_STOP: begin
          if (w_bps_clk) begin
            w_good_frame = r_sync2;
            w_frame_err  = ~r_sync2;
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_STOP;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  // Bit index and LSB-first shift register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (w_bit_clr) begin
      r_bit_idx <= '0;
    end else if (w_shift_en) begin
      r_bit_idx          <= r_bit_idx + BIT_IDX_W'(1);
      r_shift[r_bit_idx] <= r_sync2;
    end else begin
      r_bit_idx <= r_bit_idx;
    end
  end

  // Output byte, handshake and error pulses; a completing frame beats a
  // same-cycle acknowledge, and that acknowledge also suppresses overrun.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done      <= w_good_frame;
      r_frame_err <= w_frame_err;
      r_overrun   <= w_good_frame & r_rx_valid & ~RX_Ack;
      if (w_good_frame) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
      end else if (RX_Ack) begin
        r_rx_valid <= 1'b0;
      end else begin
        r_rx_valid <= r_rx_valid;
      end
    end
  end

  assign RX_Data     = r_rx_data;
  assign RX_Valid    = r_rx_valid;
  assign RX_Done_Sig = r_done;
  assign Frame_Err   = r_frame_err;
  assign Overrun_Err = r_overrun;
  assign BPS_CLK     = w_bps_clk;

endmodule

// File: tb/tb_rx_module.sv
// Self-checking bench for rx_module: a table of serial frames plus directed
// sequences for glitch rejection, mid-frame reset and receiver disable.
module tb_rx_module;

  logic       CLK;
  logic       RSTn;
  logic       RX_Pin_In;
  logic       en_RX;
  logic       RX_Ack;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig;
  logic       RX_Valid;
  logic       Frame_Err;
  logic       Overrun_Err;
  logic       BPS_CLK;

  localparam int BIT_CYC = 16;

  rx_module #(
    .CLK_FREQ (160),
    .BAUD     (10)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .RX_Pin_In   (RX_Pin_In),
    .en_RX       (en_RX),
    .RX_Ack      (RX_Ack),
    .RX_Data     (RX_Data),
    .RX_Done_Sig (RX_Done_Sig),
    .RX_Valid    (RX_Valid),
    .Frame_Err   (Frame_Err),
    .Overrun_Err (Overrun_Err),
    .BPS_CLK     (BPS_CLK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       done;
    logic       ferr;
    logic       ovr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ack_before;
    logic       exp_done;
    logic       exp_ferr;
    logic       exp_ovr;
    logic [7:0] exp_data;
    logic       exp_valid;
  } vec_t;

  ev_t  sb_q[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling clock edge and score any output pulse.
  task automatic tick();
    ev_t e;
    @(negedge CLK);
    if (RX_Done_Sig || Frame_Err || Overrun_Err) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: done=%0b ferr=%0b ovr=%0b, expected no pulse",
                 RX_Done_Sig, Frame_Err, Overrun_Err);
      end else begin
        e = sb_q.pop_front();
        check("done_pulse", {31'd0, RX_Done_Sig}, {31'd0, e.done});
        check("ferr_pulse", {31'd0, Frame_Err}, {31'd0, e.ferr});
        check("ovr_pulse", {31'd0, Overrun_Err}, {31'd0, e.ovr});
        if (e.done) begin
          check("data_at_done", {24'd0, RX_Data}, {24'd0, e.data});
        end
      end
    end
  endtask

  task automatic hold(input logic v, input int n);
    RX_Pin_In = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    hold(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      hold(d[i], BIT_CYC);
    end
    hold(stop, BIT_CYC);
    if (!stop) begin
      hold(1'b1, 20);
    end
  endtask

  task automatic push_ev(input logic done, input logic ferr, input logic ovr, input logic [7:0] data);
    ev_t e;
    e.done = done;
    e.ferr = ferr;
    e.ovr  = ovr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic ack_pulse();
    RX_Ack = 1'b1;
    tick();
    RX_Ack = 1'b0;
  endtask

  task automatic check_held(input string tag, input logic [7:0] exp_data, input logic exp_valid);
    check({tag, "_rx_data"}, {24'd0, RX_Data}, {24'd0, exp_data});
    check({tag, "_rx_valid"}, {31'd0, RX_Valid}, {31'd0, exp_valid});
    check({tag, "_sb_drained"}, sb_q.size(), 32'd0);
  endtask

  initial begin
    //          data   stop  ack   done  ferr  ovr   exp_data valid
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[2] = '{8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1};
    vecs[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1};

    RSTn      = 1'b0;
    RX_Pin_In = 1'b1;
    en_RX     = 1'b1;
    RX_Ack    = 1'b0;
    repeat (3) tick();
    check("rst_rx_data", {24'd0, RX_Data}, 32'd0);
    check("rst_rx_valid", {31'd0, RX_Valid}, 32'd0);
    check("rst_done", {31'd0, RX_Done_Sig}, 32'd0);
    check("rst_ferr", {31'd0, Frame_Err}, 32'd0);
    check("rst_ovr", {31'd0, Overrun_Err}, 32'd0);
    check("rst_bps_clk", {31'd0, BPS_CLK}, 32'd0);
    RSTn = 1'b1;
    hold(1'b1, 5);

    // Rows without an acknowledge run back-to-back with the previous frame.
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].ack_before) begin
        ack_pulse();
      end
      push_ev(vecs[v].exp_done, vecs[v].exp_ferr, vecs[v].exp_ovr, vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop);
      check_held($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_valid);
    end

    hold(1'b0, 4);
    hold(1'b1, 40);
    check_held("glitch", 8'h80, 1'b1);

    // Reset asserted halfway through data bit 3 of 0x4B.
    hold(1'b1, 5);
    hold(1'b0, BIT_CYC);
    hold(1'b1, BIT_CYC);
    hold(1'b1, BIT_CYC);
    hold(1'b0, BIT_CYC);
    hold(1'b1, BIT_CYC / 2);
    RSTn = 1'b0;
    #1;
    check("midrst_rx_data", {24'd0, RX_Data}, 32'd0);
    check("midrst_rx_valid", {31'd0, RX_Valid}, 32'd0);
    check("midrst_done", {31'd0, RX_Done_Sig}, 32'd0);
    check("midrst_ferr", {31'd0, Frame_Err}, 32'd0);
    check("midrst_ovr", {31'd0, Overrun_Err}, 32'd0);
    check("midrst_bps_clk", {31'd0, BPS_CLK}, 32'd0);
    tick();
    tick();
    RSTn = 1'b1;
    hold(1'b1, 20);
    push_ev(1'b1, 1'b0, 1'b0, 8'h5A);
    send_frame(8'h5A, 1'b1);
    check_held("after_rst", 8'h5A, 1'b1);

    // Receiver disabled after two data bits of 0x0F; rest of frame ignored.
    hold(1'b0, BIT_CYC);
    hold(1'b1, BIT_CYC);
    hold(1'b1, BIT_CYC);
    en_RX = 1'b0;
    for (int i = 2; i < 8; i++) begin
      hold((i < 4) ? 1'b1 : 1'b0, BIT_CYC);
    end
    hold(1'b1, BIT_CYC);
    en_RX = 1'b1;
    hold(1'b1, 4);
    check_held("disabled", 8'h5A, 1'b1);
    ack_pulse();
    push_ev(1'b1, 1'b0, 1'b0, 8'hFF);
    send_frame(8'hFF, 1'b1);
    check_held("reenabled", 8'hFF, 1'b1);

    hold(1'b1, 10);
    check("final_sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_module.md
RX_MODULE -- requirements
Module: rx_module

Interface
REQ-001 Parameter CLK_FREQ, 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 9600, serial bit rate; BPS_DIV = CLK_FREQ/BAUD (integer divide), BPS_HALF = BPS_DIV/2.
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 RSTn  input  1  reset, asynchronous, active-low.
REQ-005 RX_Pin_In  input  1  serial line, idle high, 8N1, LSB first.
REQ-006 en_RX  input  1  receiver enable; low holds FSM in IDLE.
REQ-007 RX_Ack  input  1  consumer acknowledge; clears RX_Valid.
REQ-008 RX_Data  output  8  last correctly framed byte.
REQ-009 RX_Done_Sig  output  1  one-cycle pulse per good frame.
REQ-010 RX_Valid  output  1  level; byte available and not yet acknowledged.
REQ-011 Frame_Err  output  1  one-cycle pulse when stop bit samples low.
REQ-012 Overrun_Err  output  1  one-cycle pulse when a good frame completes while RX_Valid is high.
REQ-013 BPS_CLK  output  1  mid-bit sample strobe, for debug.

Function
REQ-014 RX_Pin_In passes through a 2-flop synchronizer (reset value 1); all decoding uses the synchronized value.
REQ-015 Falling edge is a synchronized 1 followed by a synchronized 0.
REQ-016 FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE: on falling edge with en_RX=1, go to START and clear the bit-period counter to 0.
REQ-018 The counter increments every cycle outside IDLE and wraps from BPS_DIV-1 to 0; BPS_CLK is high for the one cycle where the counter equals BPS_HALF-1.
REQ-019 START: at BPS_CLK, line 0 -> DATA with bit index 0; line 1 -> IDLE (glitch rejection, no outputs).
REQ-020 DATA: at each BPS_CLK, shift the sampled bit into the shift register at position bit index (LSB first); after index 7 -> STOP.
REQ-021 STOP: at BPS_CLK, line 1 -> good frame; line 0 -> Frame_Err pulse, RX_Data and RX_Valid unchanged; both cases -> IDLE.
REQ-022 Good frame: in the cycle after the stop-bit BPS_CLK, RX_Data loads the shift register, RX_Done_Sig pulses and RX_Valid sets.
REQ-023 Good frame with RX_Valid already 1 and no RX_Ack in the same cycle: Overrun_Err pulses and RX_Data is overwritten.
REQ-024 RX_Ack=1 clears RX_Valid the next cycle; a simultaneous good-frame set wins, RX_Valid stays 1 and no overrun is flagged.
REQ-025 en_RX deasserted mid-frame: FSM returns to IDLE the next cycle, the partial byte is discarded and no pulses are generated.
REQ-026 A new start bit is accepted in the first IDLE cycle after STOP; there is no dead time beyond the half stop bit.

Reset
REQ-027 When RSTn=0: FSM=IDLE, counter=0, bit index=0, shift register=0, RX_Data=8'h00, RX_Valid=0, RX_Done_Sig=0, Frame_Err=0, Overrun_Err=0, BPS_CLK=0, synchronizer flops=1.
REQ-028 Reset takes effect immediately, also mid-frame; the first frame after release needs a fresh falling edge.

Structure
REQ-029 A shared package holds the FSM state encoding, DATA_BITS=8 and the BPS_DIV/BPS_HALF derivation.
REQ-030 One sub-module, rx_bps_module, implements the counter, with Count_Sig (high outside IDLE) and BPS_CLK output. The FSM, synchronizer and output registers stay in rx_module.

Verification
REQ-031 The bench uses CLK_FREQ=160 and BAUD=10 (BPS_DIV=16) unless noted otherwise.
REQ-032 Frame 0xA5 with stop=1 -> RX_Done_Sig pulses once, RX_Data=8'hA5, RX_Valid=1, Frame_Err=0.
REQ-033 Line low for 4 cycles then high -> FSM back in IDLE, no pulses, RX_Valid unchanged.
REQ-034 Frame 0x3C with stop=0 -> one Frame_Err pulse, RX_Data keeps the previous value, no RX_Done_Sig.
REQ-035 Two back-to-back frames 0x11 then 0x22 with no RX_Ack -> second frame gives an Overrun_Err pulse and RX_Data=8'h22; with RX_Ack between frames -> no Overrun_Err.
REQ-036 RSTn pulsed low during DATA bit 3 of a frame -> all outputs at reset values; next full frame 0x5A is received correctly.
REQ-037 en_RX=0 during a frame -> no pulses; re-enable, send 0xFF -> RX_Data=8'hFF.
